counter_monitor: RTL and testbench

- Checks the output of the 8-bit up/down counter on the fly.
- Samples the counter value and mode line every enabled cycle and predicts the next value: +1 when m=1, -1 when m=0, modulo 2^WIDTH.
- Flags mismatches, keeps a saturating error count, and tracks lock state.
- Reports up/down wrap-around events and direction changes.
- Used in-system as a self-check and by the bench as the scoreboard for the counter.

---
 rtl/counter_monitor.sv | 120 ++++++++++++
 tb/tb_counter_monitor.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/counter_monitor.sv
// Purpose: on-the-fly checker for an up/down counter; predicts each enabled sample and tracks lock.
// Latency: all flags and expected are registered, valid the cycle after the sampling edge.
// Backpressure: none; en low freezes every piece of state and drops all pulses.
module counter_monitor #(
    parameter int WIDTH      = 8,
    parameter int ERR_W      = 8,
    parameter int LOSS_LIMIT = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             m,
    input  logic [WIDTH-1:0] count,
    output logic             locked,
    output logic             mismatch,
    output logic [ERR_W-1:0] err_count,
    output logic             wrap_up,
    output logic             wrap_down,
    output logic             dir_change,
    output logic [WIDTH-1:0] expected
);

    typedef enum logic [1:0] {
        ACQUIRE  = 2'd0,
        PRE_LOCK = 2'd1,
        LOCKED   = 2'd2
    } state_t;

    localparam logic [WIDTH-1:0] CNT_ONE = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [ERR_W-1:0] ERR_ONE = {{(ERR_W-1){1'b0}}, 1'b1};
    localparam logic [3:0]       LIMIT   = 4'(LOSS_LIMIT);

    state_t           state, state_n;
    logic [3:0]       miss_cnt, miss_n;
    logic [WIDTH-1:0] count_p;
    logic             m_p;
    logic [ERR_W-1:0] err_n;
    logic             mismatch_n, wrap_up_n, wrap_down_n, dir_change_n;
    logic             hit;
    logic [3:0]       miss_inc;

    assign hit      = (count == expected);
    assign miss_inc = miss_cnt + 4'd1;
    assign locked   = (state == LOCKED);

    always_comb begin
        state_n      = state;
        miss_n       = miss_cnt;
        err_n        = err_count;
        mismatch_n   = 1'b0;
        wrap_up_n    = 1'b0;
        wrap_down_n  = 1'b0;
        dir_change_n = 1'b0;
        if (en) begin
            case (state)
                ACQUIRE: begin
                    state_n = PRE_LOCK;
                    miss_n  = 4'd0;
                end
                PRE_LOCK: begin
                    if (hit) state_n = LOCKED;
                end
                LOCKED: begin
                    if (hit) begin
                        miss_n = 4'd0;
                    end else begin
                        mismatch_n = 1'b1;
                        if (err_count != {ERR_W{1'b1}}) err_n = err_count + ERR_ONE;
                        if (miss_inc >= LIMIT) begin
                            state_n = ACQUIRE;
                            miss_n  = 4'd0;
                        end else begin
                            miss_n = miss_inc;
                        end
                    end
                end
                default: begin
                    state_n = ACQUIRE;
                    miss_n  = 4'd0;
                end
            endcase
            // Wrap and direction need a valid previous sample, which ACQUIRE lacks.
            if (state != ACQUIRE) begin
                wrap_up_n    = m_p  && (count_p == {WIDTH{1'b1}}) && (count == {WIDTH{1'b0}});
                wrap_down_n  = !m_p && (count_p == {WIDTH{1'b0}}) && (count == {WIDTH{1'b1}});
                dir_change_n = (m != m_p);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= ACQUIRE;
            miss_cnt   <= 4'd0;
            err_count  <= {ERR_W{1'b0}};
            expected   <= {WIDTH{1'b0}};
            count_p    <= {WIDTH{1'b0}};
            m_p        <= 1'b0;
            mismatch   <= 1'b0;
            wrap_up    <= 1'b0;
            wrap_down  <= 1'b0;
            dir_change <= 1'b0;
        end else begin
            state      <= state_n;
            miss_cnt   <= miss_n;
            err_count  <= err_n;
            mismatch   <= mismatch_n;
            wrap_up    <= wrap_up_n;
            wrap_down  <= wrap_down_n;
            dir_change <= dir_change_n;
            // Re-seed from the observed value so one glitch costs one miss, not a cascade.
            if (en) begin
                expected <= m ? (count + CNT_ONE) : (count - CNT_ONE);
                count_p  <= count;
                m_p      <= m;
            end
        end
    end

endmodule

// File: tb/tb_counter_monitor.sv
// Directed bench for counter_monitor: hand-computed vectors covering lock, wrap, glitch, loss, saturation, reset and en gaps.
module tb_counter_monitor;

    logic       clk = 1'b0;
    logic       rst, en, m;
    logic [7:0] count;
    logic       locked, mismatch, wrap_up, wrap_down, dir_change;
    logic [7:0] err_count, expected;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    counter_monitor #(.WIDTH(8), .ERR_W(8), .LOSS_LIMIT(3)) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .m          (m),
        .count      (count),
        .locked     (locked),
        .mismatch   (mismatch),
        .err_count  (err_count),
        .wrap_up    (wrap_up),
        .wrap_down  (wrap_down),
        .dir_change (dir_change),
        .expected   (expected)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Drive one cycle of inputs, let the edge pass, settle #1 before checks.
    task automatic smp(input logic e, input logic mm, input logic [7:0] c);
        en    = e;
        m     = mm;
        count = c;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        smp(1'b1, 1'b1, 8'hA5);
        rst = 1'b1;
    endtask

    initial begin
        int wu, wd, mm_n, dc, flags;
        logic [7:0] e, bad;
        rst = 1'b0; en = 1'b0; m = 1'b0; count = 8'h00;

        // Reset state
        do_reset();
        check("rst_locked",   32'(locked), 32'd0);
        check("rst_err",      32'(err_count), 32'd0);
        check("rst_expected", 32'(expected), 32'd0);
        check("rst_flags",    32'({mismatch, wrap_up, wrap_down, dir_change}), 32'd0);

        // 1: up count with wrap
        smp(1'b1, 1'b1, 8'h00);
        check("t1_locked_s1", 32'(locked), 32'd0);
        check("t1_exp_s1",    32'(expected), 32'h01);
        smp(1'b1, 1'b1, 8'h01);
        smp(1'b1, 1'b1, 8'h02);
        check("t1_locked_s3", 32'(locked), 32'd1);
        wu = 0; mm_n = 0; dc = 0;
        for (int i = 3; i <= 256; i++) begin
            smp(1'b1, 1'b1, 8'(i));
            if (wrap_up)    wu++;
            if (mismatch)   mm_n++;
            if (dir_change) dc++;
            if (i == 256) check("t1_wrap_on_ff_to_00", 32'(wrap_up), 32'd1);
        end
        check("t1_wrap_up_cnt",  32'(wu), 32'd1);
        check("t1_mismatch_cnt", 32'(mm_n), 32'd0);
        check("t1_dir_cnt",      32'(dc), 32'd0);
        check("t1_err",          32'(err_count), 32'd0);
        check("t1_exp_end",      32'(expected), 32'h01);

        // 2: direction switch, then wrap down
        for (int i = 1; i <= 16; i++) smp(1'b1, 1'b1, 8'(i));
        smp(1'b1, 1'b0, 8'h11);
        check("t2_dir_pulse",  32'(dir_change), 32'd1);
        check("t2_no_mm",      32'(mismatch), 32'd0);
        check("t2_exp_after",  32'(expected), 32'h10);
        smp(1'b1, 1'b0, 8'h10);
        check("t2_dir_once",   32'(dir_change), 32'd0);
        smp(1'b1, 1'b0, 8'h0F);
        wd = 0; mm_n = 0;
        for (int i = 14; i >= 0; i--) begin
            smp(1'b1, 1'b0, 8'(i));
            if (wrap_down) wd++;
            if (mismatch)  mm_n++;
        end
        smp(1'b1, 1'b0, 8'hFF);
        check("t2_wrap_down",    32'(wrap_down), 32'd1);
        check("t2_wd_early",     32'(wd), 32'd0);
        check("t2_mismatch_cnt", 32'(mm_n), 32'd0);
        check("t2_exp_ff",       32'(expected), 32'hFE);

        // 3: single glitch at 0x20 ascending
        smp(1'b1, 1'b1, 8'hFE);
        check("t3_dir_back_up", 32'(dir_change), 32'd1);
        for (int i = 255; i <= 288; i++) smp(1'b1, 1'b1, 8'(i));
        check("t3_exp_21", 32'(expected), 32'h21);
        smp(1'b1, 1'b1, 8'h55);
        check("t3_mm_pulse",   32'(mismatch), 32'd1);
        check("t3_err_1",      32'(err_count), 32'd1);
        check("t3_locked",     32'(locked), 32'd1);
        check("t3_exp_reseed", 32'(expected), 32'h56);
        smp(1'b1, 1'b1, 8'h56);
        check("t3_mm_clear", 32'(mismatch), 32'd0);
        smp(1'b1, 1'b1, 8'h57);
        check("t3_err_hold",   32'(err_count), 32'd1);
        check("t3_locked_end", 32'(locked), 32'd1);

        // 4: loss of lock after three consecutive misses, then relock
        do_reset();
        smp(1'b1, 1'b1, 8'h30);
        smp(1'b1, 1'b1, 8'h31);
        smp(1'b1, 1'b1, 8'h32);
        mm_n = 0;
        smp(1'b1, 1'b1, 8'h00); if (mismatch) mm_n++;
        check("t4_locked_m1", 32'(locked), 32'd1);
        smp(1'b1, 1'b1, 8'h80); if (mismatch) mm_n++;
        check("t4_locked_m2", 32'(locked), 32'd1);
        smp(1'b1, 1'b1, 8'h40); if (mismatch) mm_n++;
        check("t4_mm_cnt",     32'(mm_n), 32'd3);
        check("t4_err_3",      32'(err_count), 32'd3);
        check("t4_locked_off", 32'(locked), 32'd0);
        smp(1'b1, 1'b1, 8'h41);
        check("t4_acq_no_mm",  32'(mismatch), 32'd0);
        check("t4_acq_locked", 32'(locked), 32'd0);
        smp(1'b1, 1'b1, 8'h42);
        check("t4_relocked",   32'(locked), 32'd1);
        check("t4_err_keep",   32'(err_count), 32'd3);

        // 5: saturation, alternating miss/match keeps lock
        e = 8'h43; mm_n = 0;
        for (int i = 0; i < 300; i++) begin
            bad = e + 8'h10;
            smp(1'b1, 1'b1, bad);
            if (mismatch) mm_n++;
            if (i == 250) check("t5_err_254", 32'(err_count), 32'd254);
            smp(1'b1, 1'b1, bad + 8'h01);
            e = bad + 8'h02;
        end
        check("t5_mm_cnt", 32'(mm_n), 32'd300);
        check("t5_err_sat", 32'(err_count), 32'hFF);
        check("t5_locked",  32'(locked), 32'd1);

        // 6a: PRE_LOCK miss is silent, then build err_count=5 and reset mid-LOCKED
        do_reset();
        smp(1'b1, 1'b1, 8'h10);
        smp(1'b1, 1'b1, 8'h50);
        check("t6_prelock_silent", 32'({mismatch, locked}), 32'd0);
        check("t6_prelock_err",    32'(err_count), 32'd0);
        smp(1'b1, 1'b1, 8'h51);
        check("t6_locked", 32'(locked), 32'd1);
        e = 8'h52;
        for (int i = 0; i < 5; i++) begin
            smp(1'b1, 1'b1, e + 8'h07);
            smp(1'b1, 1'b1, e + 8'h08);
            e = e + 8'h09;
        end
        check("t6_err_5", 32'(err_count), 32'd5);
        rst = 1'b0;
        smp(1'b1, 1'b1, e + 8'h20);
        rst = 1'b1;
        check("t6_rst_locked", 32'(locked), 32'd0);
        check("t6_rst_err",    32'(err_count), 32'd0);
        check("t6_rst_exp",    32'(expected), 32'd0);
        check("t6_rst_flags",  32'({mismatch, wrap_up, wrap_down, dir_change}), 32'd0);
        smp(1'b1, 1'b0, 8'h33);
        check("t6_acq_after_rst", 32'({locked, mismatch}), 32'd0);

        // 6b: en gap with moving count and toggling m
        smp(1'b1, 1'b0, 8'h70);
        smp(1'b1, 1'b0, 8'h6F);
        check("t6_locked_down", 32'(locked), 32'd1);
        flags = 0;
        for (int i = 0; i < 4; i++) begin
            smp(1'b0, 1'(i), 8'(i * 37 + 1));
            if (mismatch || wrap_up || wrap_down || dir_change) flags++;
            if (expected !== 8'h6E) flags++;
        end
        check("t6_gap_quiet", 32'(flags), 32'd0);
        smp(1'b1, 1'b0, 8'h6E);
        check("t6_gap_no_mm",  32'(mismatch), 32'd0);
        check("t6_gap_no_dir", 32'(dir_change), 32'd0);
        check("t6_gap_locked", 32'(locked), 32'd1);
        check("t6_gap_exp",    32'(expected), 32'h6D);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
